// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared 7-segment types, blank pattern and hex encode table
package hex_disp_pkg;
    typedef logic [6:0] seg7_t;
    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex_display_ctrl_seg7_encode.sv
// seg7_encode: combinational hex nibble to active-low 7-segment pattern
module seg7_encode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit hex display with static/scan outputs, lz blanking, blink, tear-free updates
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    scan_en,
    output logic [7*NUM_DIGITS-1:0] seg_static,
    output logic [6:0]              seg_scan,
    output logic [NUM_DIGITS-1:0]   digit_sel
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [7*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
    logic [6:0]              seg_scan_q, seg_scan_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [6:0]              enc [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz;
    logic                    zero_run, tick, accept, commit;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_enc
        seg7_encode u_enc (.nibble(disp_q[4*i +: 4]), .seg(enc[i]));
    end

    always_comb begin
        tick          = scan_en && scan_cnt_q == SCAN_LAST;
        accept        = load_valid && !pend_valid_q;
        // pending data lands only on a frame wrap, or immediately once scanning stops
        commit        = pend_valid_q && (!scan_en || (tick && idx_q == IDX_LAST));
        disp_d        = commit ? pend_q : (accept && !scan_en) ? load_value : disp_q;
        pend_d        = (accept && scan_en) ? load_value : pend_q;
        pend_valid_d  = pend_valid_q ? !commit : accept && scan_en;
        scan_cnt_d    = (!scan_en || tick) ? '0 : scan_cnt_q + 1'b1;
        idx_d         = !scan_en ? '0 : tick ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        blink_cnt_d   = blink_cnt_q == BLINK_LAST ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ (blink_cnt_q == BLINK_LAST);
        lz            = '0;
        zero_run      = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && disp_q[4*i +: 4] == 4'h0;
            lz[i]    = zero_run;
        end
        seg_static_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            seg_static_d[7*i +: 7] = ((blink_phase_q && blink_mask[i]) || lz[i]) ? SEG_BLANK : enc[i];
        seg_scan_d  = scan_en ? seg_static_d[7*idx_q +: 7] : SEG_BLANK;
        digit_sel_d = scan_en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q        <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_static_q  <= '1;
            seg_scan_q    <= SEG_BLANK;
            digit_sel_q   <= '1;
        end else begin
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_static_q  <= seg_static_d;
            seg_scan_q    <= seg_scan_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign load_ready = !pend_valid_q;
    assign seg_static = seg_static_q;
    assign seg_scan   = seg_scan_q;
    assign digit_sel  = digit_sel_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed checks of hex_display_ctrl with 4 digits, fast scan and blink
module tb_hex_display_ctrl;
    localparam int N = 4;
    logic          clk = 1'b0;
    logic          rst, load_valid, load_ready, blank_lz, scan_en;
    logic [15:0]   load_value;
    logic [3:0]    blink_mask, digit_sel;
    logic [27:0]   seg_static;
    logic [6:0]    seg_scan;
    int            total = 0;
    int            passed = 0;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [27:0] exp;
    } vec_t;
    vec_t vecs [8];

    logic [3:0] sel_tab  [16] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7,
                                  4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    logic [6:0] scan_tab [16] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
                                  7'h19, 7'h19, 7'h30, 7'h30, 7'h24, 7'h24, 7'h79, 7'h79};
    logic       rdy_tab  [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(2), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .scan_en(scan_en), .seg_static(seg_static), .seg_scan(seg_scan), .digit_sel(digit_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank(input string name);
        check({name, "_seg_static"}, 32'(seg_static), 32'h0FFF_FFFF);
        check({name, "_seg_scan"}, 32'(seg_scan), 32'h7F);
        check({name, "_digit_sel"}, 32'(digit_sel), 32'hF);
        check({name, "_load_ready"}, 32'(load_ready), 32'h1);
    endtask

    initial begin
        vecs[0] = '{16'h00A5, 1'b0, {7'h40, 7'h40, 7'h08, 7'h12}};
        vecs[1] = '{16'h00A5, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h12}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[4] = '{16'h0F0E, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h06}};
        vecs[5] = '{16'hBCD6, 1'b1, {7'h03, 7'h46, 7'h21, 7'h02}};
        vecs[6] = '{16'h7890, 1'b1, {7'h78, 7'h00, 7'h10, 7'h40}};
        vecs[7] = '{16'h0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}};
        rst = 1'b1; load_valid = 1'b0; load_value = '0; blank_lz = 1'b0;
        blink_mask = '0; scan_en = 1'b0;
        step();
        step();
        check_blank("reset");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            blank_lz = vecs[i].lz;
            load_value = vecs[i].value;
            load_valid = 1'b1;
            step();
            load_valid = 1'b0;
            check("static_ready", 32'(load_ready), 32'h1);
            step();
            check("static_seg", 32'(seg_static), 32'(vecs[i].exp));
        end

        // blink: phase becomes 1 after the 4th edge past reset, output one edge later
        rst = 1'b1; blank_lz = 1'b0; blink_mask = 4'h1;
        load_value = 16'h00A5; load_valid = 1'b1;
        step();
        rst = 1'b0;
        step();
        load_valid = 1'b0;
        for (int n = 2; n < 18; n++) begin
            step();
            check("blink_seg", 32'(seg_static),
                  32'({7'h40, 7'h40, 7'h08, (((n - 1) / 4) % 2 == 1) ? 7'h7F : 7'h12}));
        end

        // scan: load mid-frame, visible only from the first slot of the next frame
        rst = 1'b1; blink_mask = '0; scan_en = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (n == 3) begin
                load_value = 16'h1234;
                load_valid = 1'b1;
            end
            step();
            load_valid = 1'b0;
            check("scan_sel", 32'(digit_sel), 32'(sel_tab[n-1]));
            check("scan_seg", 32'(seg_scan), 32'(scan_tab[n-1]));
            check("scan_ready", 32'(load_ready), 32'(rdy_tab[n-1]));
        end

        // reset discards a pending load
        load_value = 16'hABCD; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("pend_ready_low", 32'(load_ready), 32'h0);
        rst = 1'b1;
        step();
        check_blank("pend_reset");
        rst = 1'b0; scan_en = 1'b0;
        step();
        step();
        check("pend_discarded", 32'(seg_static), 32'({4{7'h40}}));

        // dropping scan_en commits the pending value on the next edge
        scan_en = 1'b1; load_value = 16'h4321; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("drop_ready_low", 32'(load_ready), 32'h0);
        scan_en = 1'b0;
        step();
        check("drop_ready_high", 32'(load_ready), 32'h1);
        check("drop_seg_old", 32'(seg_static), 32'({4{7'h40}}));
        step();
        check("drop_seg_new", 32'(seg_static), 32'({7'h19, 7'h30, 7'h24, 7'h79}));
        check("drop_sel_idle", 32'(digit_sel), 32'hF);
        check("drop_scan_idle", 32'(seg_scan), 32'h7F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised multi-digit hex display controller for DE2-115 style active-low 7-segment displays. It takes a NUM_DIGITS-nibble value over a valid/ready handshake and holds it in a display register. Outputs are provided two ways:
- static mode: one registered 7-bit pattern per digit;
- scan mode: a time-multiplexed single segment bus plus a digit select.
Adds leading-zero blanking, per-digit blinking and tear-free updates in scan mode.

Parameters:
NUM_DIGITS, 8, number of digits; legal range 1..16.
SCAN_DIV, 50000, clk cycles per digit slot in scan mode; must be >= 1.
BLINK_DIV, 25000000, clk cycles per blink phase toggle; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
load_valid  input  1  load_value is offered this cycle.
load_ready  output  1  controller can accept a load this cycle.
load_value  input  4*NUM_DIGITS  digit i = bits [4i+3:4i]; digit 0 is the least significant.
blank_lz  input  1  1 = blank leading zero digits.
blink_mask  input  NUM_DIGITS  1 = digit blinks.
scan_en  input  1  1 = scan mode, 0 = static mode.
seg_static  output  7*NUM_DIGITS  per-digit pattern; bit0 = a ... bit6 = g; active-low.
seg_scan  output  7  pattern of the selected digit; active-low.
digit_sel  output  NUM_DIGITS  one-hot, active-low digit enable.

Behaviour:
- Reset (rst=1 at an edge):
  - disp_reg, pending_reg, scan counter, digit index, blink counter, blink_phase all cleared to 0.
  - pending_valid = 0, load_ready = 1.
  - seg_static = all 7'h7F, seg_scan = 7'h7F, digit_sel = all 1s.
  - Any in-flight pending update is discarded.
- All outputs are registered.
- Handshake: a load is accepted at an edge where load_valid && load_ready. load_value must be held stable only while load_valid && !load_ready.
- Static mode (scan_en=0), acceptance at edge k:
  - disp_reg <= load_value at edge k.
  - seg_static reflects it after edge k+1 (latency 2 edges from the offered cycle).
  - load_ready stays 1.
- Scan mode (scan_en=1), acceptance at edge k:
  - pending_reg <= load_value, pending_valid <= 1, load_ready <= 0 at edge k.
  - Commit happens at the first edge where slot tick and digit index == NUM_DIGITS-1 (frame wrap): disp_reg <= pending_reg, pending_valid <= 0, load_ready <= 1 at that same edge.
- scan_en falling while pending_valid=1: commit at the next edge and set load_ready <= 1.
- Scan timing:
  - Slot counter counts 0..SCAN_DIV-1; a tick fires when it equals SCAN_DIV-1.
  - On a tick, digit index increments and wraps NUM_DIGITS-1 -> 0.
  - digit_sel = ~(1 << index); seg_scan = the final pattern of that digit.
  - When scan_en=0: counter and index held at 0, digit_sel all 1s, seg_scan 7'h7F.
- Blink:
  - Blink counter runs in both modes and wraps at BLINK_DIV-1.
  - blink_phase toggles on wrap.
  - While blink_phase=1, digits with blink_mask[i]=1 output 7'h7F.
- Leading-zero blanking (blank_lz=1): scanning from digit NUM_DIGITS-1 downward, each 0 nibble is blanked until the first nonzero digit. Digit 0 is never blanked by this rule.
- Priority per digit: blink blank > leading-zero blank > encoded nibble.
- Encoding (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- blank_lz and blink_mask are sampled live each cycle; they are not captured with the load.

Decomposition:
- Package hex_disp_pkg:
  - typedef seg7_t (logic [6:0]);
  - constant SEG_BLANK = 7'h7F;
  - the 16-entry encode table as a constant array.
- Sub-module seg7_encode: combinational nibble -> seg7_t. Instantiated NUM_DIGITS times to feed seg_static; seg_scan is a mux of those results.

Test Plan:
- Reset, then static load 32'h0000_00A5 with blank_lz=0 -> after 2 edges, digit0=12, digit1=08, digits 2-7=40; load_ready stays 1.
- Same value with blank_lz=1 -> digits 2-7=7F, digits 0-1 unchanged. Load 32'h0 -> only digit0=40, rest 7F.
- blink_mask=8'h01, BLINK_DIV=4 -> digit0 alternates 12 / 7F every 4 cycles; other digits steady.
- Scan mode, SCAN_DIV=2, NUM_DIGITS=4:
  - digit_sel cycles E,D,B,7, changing every 2 cycles.
  - Load 16'h1234 mid-frame -> load_ready=0 until frame wrap, then seg_scan shows 19 with digit_sel=E.
  - No torn frame.
- Load pending, then rst asserted -> pending discarded, all outputs blank, load_ready=1, disp_reg=0.
- Load pending in scan mode, then scan_en dropped -> commit on the next edge, load_ready=1, seg_static shows the new value one edge later.
